acc_cpu_core: RTL and testbench
===============================

Name: acc_cpu_core

Overview:
- Parametrised successor of the team's 6-bit accumulator CPU.
- Adds configurable data width, a separate hardware call stack with overflow/underflow fault, store/load to data memory, and borrow-aware subtraction.
- Adds a programmable step-rate divider and a memory load port usable while the core is held in reset.
- Sits between the board loader (writes program/data) and the LED/debug outputs (acc, flags, pc, status).

Parameters:
DW, 8, data/accumulator width and instruction operand width (DW >= AW)
AW, 6, address width of program and data memory (2^AW words each)
SD, 8, call-stack depth in entries (>= 1)
TICK_DIV, 50000000, clk cycles per instruction step (>= 3)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
ld_prog_we  in  1  program memory write strobe (honoured only while reset==0)
ld_data_we  in  1  data memory write strobe (honoured only while reset==0)
ld_addr  in  AW  load address
ld_wdata  in  6+DW  load data; data memory uses bits [DW-1:0]
acc  out  DW  accumulator
carry  out  1  carry / borrow flag
parity  out  1  1 = even number of ones in acc
sign  out  1  acc[DW-1]
zero  out  1  acc == 0
pc  out  AW  program counter
halted  out  1  HLT executed
stack_err  out  1  stack overflow/underflow fault

Behaviour:
- Instruction format: [DW+5:DW] opcode, [DW-1:0] operand. Address operand = operand[AW-1:0].
- Opcodes: ADD 000000, SUB 000001, CALL 000010, JMP 000011, OR 000100, AND 000101, JNZ 000110, XOR 000111, JNC 001000, MVI 001001, ADI 001010, SUBI 001011, ORI 001100, ANI 001101, RET 001110, STA 010000, LDA 010001, JZ 010010, JC 010011, HLT 111111. Any other opcode is a NOP (pc+1).
- Reset (reset==0): acc=0, all flags 0, pc=0, sp=0, halted=0, stack_err=0, tick counter=0, state=IDLE. Memories are not cleared.
- Load port: writes occur on the same clk edge while reset==0. Write strobes are ignored while running.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 in the cycle counter==TICK_DIV-1.
- FSM states: IDLE, FETCH, EXEC, HALT, FAULT.
  - IDLE: tick -> FETCH.
  - FETCH: synchronous read prog_mem[pc] -> EXEC.
  - EXEC: execute, pc updated -> IDLE, or HALT (HLT), or FAULT (stack error).
  - Exactly one instruction per tick. Architectural state changes only on the EXEC edge.
- Arithmetic, all modulo 2^DW:
  - ADD/ADI: {carry,acc} = acc + operand.
  - SUB/SUBI: acc = acc - operand; carry = 1 iff borrow (acc < operand, unsigned).
  - OR/AND/XOR/ORI/ANI/MVI/LDA: carry=0.
- Flag update: parity, sign and zero are recomputed from the NEW acc in the same EXEC edge for every ALU/MVI/LDA op.
- Flags unaffected by: JMP, JNZ, JZ, JNC, JC, CALL, RET, STA, NOP.
- Memory ops: ADD/SUB/OR/AND/XOR/LDA read data_mem[addr]. Data memory is read combinationally or pre-fetched in FETCH, so no extra step is needed. STA: data_mem[addr] = acc.
- Branches:
  - JNZ jumps if zero==0; JZ if zero==1; JNC if carry==0; JC if carry==1.
  - Not taken -> pc+1. pc wraps 2^AW-1 -> 0.
- CALL:
  - sp < SD: stack[sp] = pc+1; sp++; pc = target.
  - sp == SD: no push, stack_err=1, -> FAULT.
- RET:
  - sp > 0: sp--; pc = stack[sp-1].
  - sp == 0: stack_err=1, -> FAULT.
- HALT/FAULT: terminal. HLT sets halted=1 and leaves pc pointing at the HLT. Outputs hold; only reset exits.
- Reset asserted mid-instruction (any state) aborts the instruction: no partial acc/pc/memory update.

Test Plan (DW=8, AW=6, SD=2, TICK_DIV=4):
- Load MVI 0xFF, ADI 0x01, HLT -> after step 2: acc=0x00, carry=1, zero=1, parity=1, sign=0; after step 3: halted=1, pc=2; steps are exactly 4 clk apart.
- MVI 0x03, SUBI 0x05 -> acc=0xFE, carry=1, sign=1, zero=0, parity=0; then JC 0x10 -> pc=0x10.
- MVI 0x5A, STA 0x20, MVI 0, LDA 0x20 -> acc=0x5A, data_mem[0x20]=0x5A, parity=1.
- Three nested CALLs with SD=2 -> third CALL sets stack_err=1, pc holds the 2nd call's target, FSM frozen; RET at sp=0 in a separate program -> stack_err=1.
- CALL 0x08 at pc=0, RET at 0x08 -> pc=1, sp back to 0; unknown opcode 0x2A -> pc+1, flags unchanged.
- Assert reset in EXEC cycle of ADI -> acc=0, pc=0. Loader writes made during reset are readable after release, and ld_prog_we pulsed while running has no effect.

Source files
------------

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: parametrised accumulator CPU with a hardware call stack and a data memory.
// Executes one instruction per tick; both memories can be loaded while the core is held in reset.
//
// state | meaning
// IDLE  | waiting for the next step tick
// FETCH | synchronous read of prog_mem[pc] into ir
// EXEC  | execute ir, update acc/flags/pc/sp/data_mem
// HALT  | HLT executed, outputs frozen until reset
// FAULT | stack overflow/underflow, outputs frozen until reset
module acc_cpu_core #(
   parameter int DW       = 8,
   parameter int AW       = 6,
   parameter int SD       = 8,
   parameter int TICK_DIV = 50000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_prog_we,
   input  logic          ld_data_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW+5:0] ld_wdata,
   output logic [DW-1:0] acc,
   output logic          carry,
   output logic          parity,
   output logic          sign,
   output logic          zero,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic          stack_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_HALT  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_CALL = 6'b000010;
   localparam logic [5:0] OP_JMP  = 6'b000011;
   localparam logic [5:0] OP_OR   = 6'b000100;
   localparam logic [5:0] OP_AND  = 6'b000101;
   localparam logic [5:0] OP_JNZ  = 6'b000110;
   localparam logic [5:0] OP_XOR  = 6'b000111;
   localparam logic [5:0] OP_JNC  = 6'b001000;
   localparam logic [5:0] OP_MVI  = 6'b001001;
   localparam logic [5:0] OP_ADI  = 6'b001010;
   localparam logic [5:0] OP_SUBI = 6'b001011;
   localparam logic [5:0] OP_ORI  = 6'b001100;
   localparam logic [5:0] OP_ANI  = 6'b001101;
   localparam logic [5:0] OP_RET  = 6'b001110;
   localparam logic [5:0] OP_STA  = 6'b010000;
   localparam logic [5:0] OP_LDA  = 6'b010001;
   localparam logic [5:0] OP_JZ   = 6'b010010;
   localparam logic [5:0] OP_JC   = 6'b010011;
   localparam logic [5:0] OP_HLT  = 6'b111111;

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SPW = $clog2(SD + 1);
   localparam int SIW = (SD > 1) ? $clog2(SD) : 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(SD);
   localparam logic [TCW-1:0] TC_LAST = TCW'(TICK_DIV - 1);

   logic [DW+5:0] prog_mem  [0:(1<<AW)-1];
   logic [DW-1:0] data_mem  [0:(1<<AW)-1];
   logic [AW-1:0] stack_mem [0:SD-1];

   logic [2:0]     state;
   logic [TCW-1:0] tick_cnt;
   logic           tick;
   logic [DW+5:0]  ir;
   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_dec;
   logic [5:0]     opcode;
   logic [DW-1:0]  operand;
   logic [DW-1:0]  mem_rd;
   logic [AW-1:0]  addr;
   logic [AW-1:0]  pc_inc;
   logic           in_exec;
   logic           call_ok;
   logic           ret_ok;
   logic           alu_wr;
   logic           alu_carry;
   logic [DW-1:0]  alu_acc;

   assign tick    = (tick_cnt == TC_LAST);
   assign opcode  = ir[DW+5:DW];
   assign operand = ir[DW-1:0];
   assign addr    = operand[AW-1:0];
   assign mem_rd  = data_mem[addr];
   assign pc_inc  = pc + AW'(1);
   assign sp_dec  = sp - SPW'(1);
   assign in_exec = (state == S_EXEC);
   assign call_ok = in_exec && (opcode == OP_CALL) && (sp < SP_FULL);
   assign ret_ok  = in_exec && (opcode == OP_RET) && (sp != '0);

   // The carry-out bit of the DW+1 wide subtraction is the unsigned borrow.
   always_comb begin
      alu_wr    = 1'b0;
      alu_acc   = acc;
      alu_carry = 1'b0;
      case (opcode)
         OP_ADD: begin
            {alu_carry, alu_acc} = {1'b0, acc} + {1'b0, mem_rd};
            alu_wr = 1'b1;
         end
         OP_ADI: begin
            {alu_carry, alu_acc} = {1'b0, acc} + {1'b0, operand};
            alu_wr = 1'b1;
         end
         OP_SUB: begin
            {alu_carry, alu_acc} = {1'b0, acc} - {1'b0, mem_rd};
            alu_wr = 1'b1;
         end
         OP_SUBI: begin
            {alu_carry, alu_acc} = {1'b0, acc} - {1'b0, operand};
            alu_wr = 1'b1;
         end
         OP_OR: begin
            alu_acc = acc | mem_rd;
            alu_wr  = 1'b1;
         end
         OP_AND: begin
            alu_acc = acc & mem_rd;
            alu_wr  = 1'b1;
         end
         OP_XOR: begin
            alu_acc = acc ^ mem_rd;
            alu_wr  = 1'b1;
         end
         OP_ORI: begin
            alu_acc = acc | operand;
            alu_wr  = 1'b1;
         end
         OP_ANI: begin
            alu_acc = acc & operand;
            alu_wr  = 1'b1;
         end
         OP_MVI: begin
            alu_acc = operand;
            alu_wr  = 1'b1;
         end
         OP_LDA: begin
            alu_acc = mem_rd;
            alu_wr  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         tick_cnt  <= '0;
         ir        <= '0;
         pc        <= '0;
         sp        <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         parity    <= 1'b0;
         sign      <= 1'b0;
         zero      <= 1'b0;
         halted    <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);
         case (state)
            S_IDLE: begin
               if (tick) state <= S_FETCH;
            end
            S_FETCH: begin
               ir    <= prog_mem[pc];
               state <= S_EXEC;
            end
            S_EXEC: begin
               state <= S_IDLE;
               pc    <= pc_inc;
               if (alu_wr) begin
                  acc    <= alu_acc;
                  carry  <= alu_carry;
                  parity <= ~^alu_acc;
                  sign   <= alu_acc[DW-1];
                  zero   <= (alu_acc == '0);
               end
               case (opcode)
                  OP_JMP: pc <= addr;
                  OP_JNZ: if (!zero) pc <= addr;
                  OP_JZ:  if (zero) pc <= addr;
                  OP_JNC: if (!carry) pc <= addr;
                  OP_JC:  if (carry) pc <= addr;
                  OP_CALL: begin
                     if (call_ok) begin
                        sp <= sp + SPW'(1);
                        pc <= addr;
                     end else begin
                        pc        <= pc;
                        stack_err <= 1'b1;
                        state     <= S_FAULT;
                     end
                  end
                  OP_RET: begin
                     if (ret_ok) begin
                        sp <= sp_dec;
                        pc <= stack_mem[sp_dec[SIW-1:0]];
                     end else begin
                        pc        <= pc;
                        stack_err <= 1'b1;
                        state     <= S_FAULT;
                     end
                  end
                  OP_HLT: begin
                     pc     <= pc;
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && ld_prog_we) prog_mem[ld_addr] <= ld_wdata;
   end

   // Loader owns data memory during reset; STA owns it while running.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (ld_data_we) data_mem[ld_addr] <= ld_wdata[DW-1:0];
      end else if (in_exec && (opcode == OP_STA)) begin
         data_mem[addr] <= acc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && call_ok) stack_mem[sp[SIW-1:0]] <= pc_inc;
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed self-checking bench for acc_cpu_core (DW=8, AW=6, SD=2, TICK_DIV=4).
// Step k of a run completes on clock edge 2+4k after reset release.
module tb_acc_cpu_core;
   localparam int DW       = 8;
   localparam int AW       = 6;
   localparam int SD       = 2;
   localparam int TICK_DIV = 4;

   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_SUB  = 6'h01;
   localparam logic [5:0] OP_CALL = 6'h02;
   localparam logic [5:0] OP_JMP  = 6'h03;
   localparam logic [5:0] OP_XOR  = 6'h07;
   localparam logic [5:0] OP_JNC  = 6'h08;
   localparam logic [5:0] OP_MVI  = 6'h09;
   localparam logic [5:0] OP_ADI  = 6'h0A;
   localparam logic [5:0] OP_SUBI = 6'h0B;
   localparam logic [5:0] OP_RET  = 6'h0E;
   localparam logic [5:0] OP_STA  = 6'h10;
   localparam logic [5:0] OP_LDA  = 6'h11;
   localparam logic [5:0] OP_JC   = 6'h13;
   localparam logic [5:0] OP_UNK  = 6'h2A;
   localparam logic [5:0] OP_HLT  = 6'h3F;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ld_prog_we = 1'b0;
   logic          ld_data_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW+5:0] ld_wdata = '0;
   logic [DW-1:0] acc;
   logic          carry, parity, sign, zero;
   logic [AW-1:0] pc;
   logic          halted, stack_err;

   int n_checks = 0;
   int n_errs   = 0;
   int edge_now = 0;

   acc_cpu_core #(.DW(DW), .AW(AW), .SD(SD), .TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_prog_we (ld_prog_we),
      .ld_data_we (ld_data_we),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .acc        (acc),
      .carry      (carry),
      .parity     (parity),
      .sign       (sign),
      .zero       (zero),
      .pc         (pc),
      .halted     (halted),
      .stack_err  (stack_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW+5:0] ins(input logic [5:0] op, input logic [DW-1:0] opd);
      return {op, opd};
   endfunction

   task automatic put_prog(input logic [AW-1:0] a, input logic [DW+5:0] w);
      ld_addr    = a;
      ld_wdata   = w;
      ld_prog_we = 1'b1;
      @(posedge clk); #1;
      ld_prog_we = 1'b0;
   endtask

   task automatic put_data(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ld_addr    = a;
      ld_wdata   = {6'h00, d};
      ld_data_we = 1'b1;
      @(posedge clk); #1;
      ld_data_we = 1'b0;
   endtask

   task automatic enter_reset;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic release_reset;
      reset    = 1'b1;
      edge_now = 0;
   endtask

   task automatic to_edge(input int n);
      while (edge_now < n) begin
         @(posedge clk); #1;
         edge_now++;
      end
   endtask

   task automatic after_step(input int k);
      to_edge(2 + 4 * k);
   endtask

   initial begin
      @(posedge clk); #1;
      enter_reset;

      // ADI overflow, flag update and step spacing
      put_prog(6'h00, ins(OP_MVI, 8'hFF));
      put_prog(6'h01, ins(OP_ADI, 8'h01));
      put_prog(6'h02, ins(OP_HLT, 8'h00));
      check("rst_acc", 32'(acc), 'h00);
      check("rst_flags", 32'({carry, parity, sign, zero}), 'b0000);
      check("rst_pc", 32'(pc), 'h00);
      check("rst_halt_err", 32'({halted, stack_err}), 'b00);
      release_reset;
      to_edge(5);
      check("t1_no_early_step", 32'(acc), 'h00);
      to_edge(6);
      check("t1_mvi_acc", 32'(acc), 'hFF);
      check("t1_mvi_flags", 32'({carry, parity, sign, zero}), 'b0110);
      check("t1_mvi_pc", 32'(pc), 'h01);
      to_edge(9);
      check("t1_gap_acc", 32'(acc), 'hFF);
      to_edge(10);
      check("t1_adi_acc", 32'(acc), 'h00);
      check("t1_adi_flags", 32'({carry, parity, sign, zero}), 'b1101);
      check("t1_adi_pc", 32'(pc), 'h02);
      to_edge(14);
      check("t1_halted", 32'(halted), 'h1);
      check("t1_hlt_pc", 32'(pc), 'h02);
      to_edge(22);
      check("t1_hold", 32'({halted, pc, acc}), {1'b1, 6'h02, 8'h00});

      // SUBI borrow, JNC not taken, JC taken
      enter_reset;
      put_prog(6'h00, ins(OP_MVI, 8'h03));
      put_prog(6'h01, ins(OP_SUBI, 8'h05));
      put_prog(6'h02, ins(OP_JNC, 8'h30));
      put_prog(6'h03, ins(OP_JC, 8'h10));
      put_prog(6'h10, ins(OP_HLT, 8'h00));
      release_reset;
      after_step(2);
      check("t2_subi_acc", 32'(acc), 'hFE);
      check("t2_subi_flags", 32'({carry, parity, sign, zero}), 'b1010);
      after_step(3);
      check("t2_jnc_pc", 32'(pc), 'h03);
      after_step(4);
      check("t2_jc_pc", 32'(pc), 'h10);
      check("t2_jc_flags", 32'({carry, parity, sign, zero}), 'b1010);
      after_step(5);
      check("t2_halt", 32'({halted, pc, acc}), {1'b1, 6'h10, 8'hFE});

      // STA/LDA round trip, memory ALU ops, loader data write
      enter_reset;
      put_data(6'h21, 8'h3C);
      put_prog(6'h00, ins(OP_MVI, 8'h5A));
      put_prog(6'h01, ins(OP_STA, 8'h20));
      put_prog(6'h02, ins(OP_MVI, 8'h00));
      put_prog(6'h03, ins(OP_LDA, 8'h20));
      put_prog(6'h04, ins(OP_ADD, 8'h20));
      put_prog(6'h05, ins(OP_XOR, 8'h20));
      put_prog(6'h06, ins(OP_SUB, 8'h20));
      put_prog(6'h07, ins(OP_LDA, 8'h21));
      put_prog(6'h08, ins(OP_HLT, 8'h00));
      release_reset;
      after_step(3);
      check("t3_mvi0", 32'({acc, carry, parity, sign, zero}), {8'h00, 4'b0101});
      after_step(4);
      check("t3_lda", 32'({acc, carry, parity, sign, zero}), {8'h5A, 4'b0100});
      check("t3_mem20", 32'(dut.data_mem[6'h20]), 'h5A);
      after_step(5);
      check("t3_add", 32'({acc, carry, parity, sign, zero}), {8'hB4, 4'b0110});
      after_step(6);
      check("t3_xor", 32'({acc, carry, parity, sign, zero}), {8'hEE, 4'b0110});
      after_step(7);
      check("t3_sub", 32'({acc, carry, parity, sign, zero}), {8'h94, 4'b0010});
      after_step(8);
      check("t3_lda_loaded", 32'({acc, carry, parity, sign, zero}), {8'h3C, 4'b0100});
      after_step(9);
      check("t3_halt", 32'({halted, pc}), {1'b1, 6'h08});

      // stack overflow on third nested CALL
      enter_reset;
      put_prog(6'h00, ins(OP_CALL, 8'h08));
      put_prog(6'h08, ins(OP_CALL, 8'h10));
      put_prog(6'h10, ins(OP_CALL, 8'h18));
      put_prog(6'h18, ins(OP_HLT, 8'h00));
      release_reset;
      after_step(1);
      check("t4_call1_pc", 32'(pc), 'h08);
      after_step(2);
      check("t4_call2_pc", 32'(pc), 'h10);
      check("t4_call2_sp", 32'(dut.sp), 'h2);
      after_step(3);
      check("t4_ovf_err", 32'(stack_err), 'h1);
      check("t4_ovf_pc", 32'(pc), 'h10);
      after_step(5);
      check("t4_frozen", 32'({stack_err, halted, pc}), {1'b1, 1'b0, 6'h10});

      // stack underflow on RET with empty stack
      enter_reset;
      check("t4_rst_err", 32'(stack_err), 'h0);
      put_prog(6'h00, ins(OP_RET, 8'h00));
      release_reset;
      after_step(1);
      check("t4_unf_err", 32'(stack_err), 'h1);
      check("t4_unf_pc", 32'(pc), 'h00);
      after_step(2);
      check("t4_unf_frozen", 32'({stack_err, halted, pc}), {1'b1, 1'b0, 6'h00});

      // CALL/RET round trip, unknown opcode acts as NOP
      enter_reset;
      put_prog(6'h00, ins(OP_CALL, 8'h08));
      put_prog(6'h08, ins(OP_RET, 8'h00));
      put_prog(6'h01, ins(OP_MVI, 8'h80));
      put_prog(6'h02, ins(OP_UNK, 8'h00));
      put_prog(6'h03, ins(OP_HLT, 8'h00));
      release_reset;
      after_step(1);
      check("t5_call", 32'({pc, dut.sp}), {6'h08, 2'd1});
      after_step(2);
      check("t5_ret", 32'({pc, dut.sp}), {6'h01, 2'd0});
      after_step(3);
      check("t5_mvi80", 32'({acc, carry, parity, sign, zero}), {8'h80, 4'b0010});
      after_step(4);
      check("t5_nop_pc", 32'(pc), 'h03);
      check("t5_nop_state", 32'({acc, carry, parity, sign, zero}), {8'h80, 4'b0010});
      after_step(5);
      check("t5_halt", 32'({halted, stack_err, pc}), {1'b1, 1'b0, 6'h03});

      // reset during EXEC of ADI, then loader ignored while running
      enter_reset;
      put_prog(6'h00, ins(OP_MVI, 8'h10));
      put_prog(6'h01, ins(OP_ADI, 8'h01));
      put_prog(6'h02, ins(OP_HLT, 8'h00));
      release_reset;
      after_step(1);
      check("t6_mvi", 32'(acc), 'h10);
      to_edge(9);
      reset = 1'b0;
      to_edge(10);
      check("t6_abort", 32'({acc, pc, carry, zero}), {8'h00, 6'h00, 2'b00});
      put_prog(6'h00, ins(OP_MVI, 8'h11));
      put_prog(6'h01, ins(OP_HLT, 8'h00));
      release_reset;
      to_edge(2);
      ld_addr    = 6'h01;
      ld_wdata   = ins(OP_MVI, 8'h77);
      ld_prog_we = 1'b1;
      to_edge(3);
      ld_prog_we = 1'b0;
      after_step(1);
      check("t6_reload", 32'(acc), 'h11);
      after_step(2);
      check("t6_ignored_we", 32'({halted, pc, acc}), {1'b1, 6'h01, 8'h11});

      // pc wrap from 2^AW-1 to 0
      enter_reset;
      put_prog(6'h00, ins(OP_JMP, 8'h3F));
      put_prog(6'h3F, ins(OP_MVI, 8'h01));
      release_reset;
      after_step(1);
      check("t7_jmp", 32'(pc), 'h3F);
      after_step(2);
      check("t7_wrap", 32'({pc, acc}), {6'h00, 8'h01});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
